// File: rtl/crc8_frame_receiver.sv
// -----------------------------------------------------------------------------
// crc8_frame_receiver
// Receive-side deframer for the application-layer byte link. Hunts for
// SYNC_BYTE, then collects 4 payload bytes (MSB first) and 1 CRC byte. The
// CRC8 is recomputed over the payload (poly 0xD5, init 0x00, no reflection,
// no final XOR). The word and a crc_ok flag go out on a valid/ready port.
//
// Optional feature: define RX_DROP_BAD_CRC_EN to discard frames whose CRC
// does not match instead of delivering them with out_crc_ok=0.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_data    received byte
//   in_valid   in_data valid
//   in_ready   receiver can accept a byte (low only while an output is held)
//   out_data   assembled payload, first byte in [31:24]
//   out_crc_ok received CRC matched the recomputed CRC
//   out_valid  out_data/out_crc_ok valid
//   out_ready  consumer accepts the output
//   frame_err  one-cycle pulse on timeout abort or CRC mismatch
//   err_count  saturating count of frame_err pulses
// -----------------------------------------------------------------------------
module crc8_frame_receiver #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned IDLE_TIMEOUT = 1024,
   parameter int unsigned TO_WIDTH     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_crc_ok,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_err,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {HUNT, DATA, CHECK, HOLD} state_t;

   // Timeout fires on the idle cycle that would bring the gap count to
   // IDLE_TIMEOUT, i.e. when the registered count already equals IDLE_TIMEOUT-1.
   localparam bit                  TO_EN   = (IDLE_TIMEOUT != 0);
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(IDLE_TIMEOUT - 1);

   state_t              state_reg, state_next;
   logic [1:0]          idx_reg, idx_next;
   logic [7:0]          crc_reg, crc_next;
   logic [31:0]         payload_reg, payload_next;
   logic [TO_WIDTH-1:0] gap_reg, gap_next;
   logic [31:0]         out_data_reg, out_data_next;
   logic                out_crc_ok_reg, out_crc_ok_next;
   logic                out_valid_reg, out_valid_next;
   logic                frame_err_reg, frame_err_next;
   logic [7:0]          err_count_reg, err_count_next;

   logic                accept;
   logic                crc_match;
   logic                timed_out;
   logic [7:0]          err_count_inc;

   // Byte-wide CRC8 update: fold the byte in, then 8 MSB-first shift steps.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'hD5) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   assign in_ready      = (state_reg != HOLD);
   assign accept        = in_valid && in_ready;
   assign crc_match     = (in_data == crc_reg);
   assign timed_out     = TO_EN && !accept && (gap_reg == TO_LAST);
   assign err_count_inc = (err_count_reg == 8'hFF) ? err_count_reg : err_count_reg + 8'd1;

   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      crc_next        = crc_reg;
      payload_next    = payload_reg;
      gap_next        = gap_reg;
      out_data_next   = out_data_reg;
      out_crc_ok_next = out_crc_ok_reg;
      out_valid_next  = out_valid_reg;
      frame_err_next  = 1'b0;
      err_count_next  = err_count_reg;

      case (state_reg)
         HUNT: begin
            gap_next = '0;
            if (accept && in_data == SYNC_BYTE) begin
               state_next = DATA;
               idx_next   = 2'd0;
               crc_next   = 8'h00;
            end
         end

         DATA: begin
            if (accept) begin
               gap_next     = '0;
               payload_next = {payload_reg[23:0], in_data};
               crc_next     = crc8_update(crc_reg, in_data);
               idx_next     = idx_reg + 2'd1;
               if (idx_reg == 2'd3) begin
                  state_next = CHECK;
               end
            end else if (timed_out) begin
               state_next     = HUNT;
               gap_next       = '0;
               frame_err_next = 1'b1;
               err_count_next = err_count_inc;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end

         CHECK: begin
            if (accept) begin
               gap_next = '0;
               if (!crc_match) begin
                  frame_err_next = 1'b1;
                  err_count_next = err_count_inc;
               end
`ifdef RX_DROP_BAD_CRC_EN
               if (crc_match) begin
                  out_data_next   = payload_reg;
                  out_crc_ok_next = 1'b1;
                  out_valid_next  = 1'b1;
                  state_next      = HOLD;
               end else begin
                  state_next = HUNT;
               end
`else
               out_data_next   = payload_reg;
               out_crc_ok_next = crc_match;
               out_valid_next  = 1'b1;
               state_next      = HOLD;
`endif
            end else if (timed_out) begin
               state_next     = HUNT;
               gap_next       = '0;
               frame_err_next = 1'b1;
               err_count_next = err_count_inc;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end

         HOLD: begin
            gap_next = '0;
            if (out_valid_reg && out_ready) begin
               out_valid_next = 1'b0;
               state_next     = HUNT;
            end
         end

         default: state_next = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= HUNT;
         idx_reg        <= 2'd0;
         crc_reg        <= 8'h00;
         payload_reg    <= 32'h0;
         gap_reg        <= '0;
         out_data_reg   <= 32'h0;
         out_crc_ok_reg <= 1'b0;
         out_valid_reg  <= 1'b0;
         frame_err_reg  <= 1'b0;
         err_count_reg  <= 8'h00;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         crc_reg        <= crc_next;
         payload_reg    <= payload_next;
         gap_reg        <= gap_next;
         out_data_reg   <= out_data_next;
         out_crc_ok_reg <= out_crc_ok_next;
         out_valid_reg  <= out_valid_next;
         frame_err_reg  <= frame_err_next;
         err_count_reg  <= err_count_next;
      end
   end

   assign out_data   = out_data_reg;
   assign out_crc_ok = out_crc_ok_reg;
   assign out_valid  = out_valid_reg;
   assign frame_err  = frame_err_reg;
   assign err_count  = err_count_reg;

endmodule

// File: tb/tb_crc8_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_crc8_frame_receiver
// Directed bench for crc8_frame_receiver (IDLE_TIMEOUT overridden to 8).
// Covers reset values, good frames, held output, CRC error, sync hunting,
// inter-byte timeout and reset mid-frame. Honors RX_DROP_BAD_CRC_EN.
// -----------------------------------------------------------------------------
module tb_crc8_frame_receiver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_crc_ok;
   logic        out_valid;
   logic        out_ready;
   logic        frame_err;
   logic [7:0]  err_count;

   int n_assert = 0;
   int n_fail   = 0;

   crc8_frame_receiver #(
      .SYNC_BYTE    (8'hA5),
      .IDLE_TIMEOUT (8),
      .TO_WIDTH     (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_crc_ok (out_crc_ok),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_err  (frame_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // Bit-serial reference CRC8 (poly 0xD5, init 0), MSB first over the word.
   function automatic logic [7:0] crc8_model(input logic [31:0] w);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 31; i >= 0; i--) begin
         fb = c[7] ^ w[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'hD5 : 8'h00);
      end
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer one byte for exactly one clock edge; returns #1 after that edge.
   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] w, input logic [7:0] crc);
      send(8'hA5);
      send(w[31:24]);
      send(w[23:16]);
      send(w[15:8]);
      send(w[7:0]);
      send(crc);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] crc_dbef;
      rst_n     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      crc_dbef  = crc8_model(32'hDEADBEEF);

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_out_data",   out_data,        32'h0);
      chk("rst_out_crc_ok", 32'(out_crc_ok), 32'd0);
      chk("rst_frame_err",  32'(frame_err),  32'd0);
      chk("rst_err_count",  32'(err_count),  32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: good frame, consumer ready, output lasts one cycle
      out_ready = 1'b1;
      send_frame(32'h00000001, 8'hD5);
      $display("frame 1: data=%h crc_ok=%b valid=%b", out_data, out_crc_ok, out_valid);
      chk("f1_valid",     32'(out_valid),  32'd1);
      chk("f1_data",      out_data,        32'h00000001);
      chk("f1_crc_ok",    32'(out_crc_ok), 32'd1);
      chk("f1_frame_err", 32'(frame_err),  32'd0);
      chk("f1_err_count", 32'(err_count),  32'd0);
      @(posedge clk);
      #1;
      chk("f1_valid_drop", 32'(out_valid), 32'd0);
      chk("f1_ready_back", 32'(in_ready),  32'd1);
      out_ready = 1'b0;

      // 2: good frame held for 5 cycles while a byte is offered
      send_frame(32'h01000000, 8'h45);
      $display("frame 2: data=%h crc_ok=%b valid=%b", out_data, out_crc_ok, out_valid);
      chk("f2_valid",  32'(out_valid),  32'd1);
      chk("f2_data",   out_data,        32'h01000000);
      chk("f2_crc_ok", 32'(out_crc_ok), 32'd1);
      in_data  = 8'h77;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("f2_hold_ready", 32'(in_ready),  32'd0);
         chk("f2_hold_valid", 32'(out_valid), 32'd1);
         chk("f2_hold_data",  out_data,       32'h01000000);
      end
      in_valid = 1'b0;
      release_out("f2");

      // 3: CRC error
      send_frame(32'h00000001, 8'hD4);
      $display("frame 3: data=%h crc_ok=%b valid=%b err=%b", out_data, out_crc_ok, out_valid, frame_err);
      chk("f3_frame_err", 32'(frame_err), 32'd1);
      chk("f3_err_count", 32'(err_count), 32'd1);
`ifdef RX_DROP_BAD_CRC_EN
      chk("f3_valid",     32'(out_valid), 32'd0);
      chk("f3_ready",     32'(in_ready),  32'd1);
`else
      chk("f3_valid",     32'(out_valid),  32'd1);
      chk("f3_crc_ok",    32'(out_crc_ok), 32'd0);
      chk("f3_data",      out_data,        32'h00000001);
`endif
      @(posedge clk);
      #1;
      chk("f3_err_pulse_end", 32'(frame_err), 32'd0);
      release_out("f3");

      // 4: hunt past junk bytes
      send(8'h00);
      send(8'hFF);
      send_frame(32'hDEADBEEF, crc_dbef);
      $display("frame 4: data=%h crc_ok=%b valid=%b", out_data, out_crc_ok, out_valid);
      chk("f4_valid",     32'(out_valid),  32'd1);
      chk("f4_data",      out_data,        32'hDEADBEEF);
      chk("f4_crc_ok",    32'(out_crc_ok), 32'd1);
      chk("f4_err_count", 32'(err_count),  32'd1);
      release_out("f4");

      // 5: timeout after 8 idle cycles mid-frame, then a normal frame
      send(8'hA5);
      send(8'h11);
      send(8'h22);
      repeat (7) @(posedge clk);
      #1;
      chk("to_no_err_yet", 32'(frame_err), 32'd0);
      @(posedge clk);
      #1;
      $display("timeout: frame_err=%b err_count=%0d", frame_err, err_count);
      chk("to_frame_err", 32'(frame_err), 32'd1);
      chk("to_err_count", 32'(err_count), 32'd2);
      chk("to_valid",     32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("to_err_pulse_end", 32'(frame_err), 32'd0);
      send_frame(32'h00000001, 8'hD5);
      $display("frame 5: data=%h crc_ok=%b valid=%b", out_data, out_crc_ok, out_valid);
      chk("f5_valid",  32'(out_valid),  32'd1);
      chk("f5_data",   out_data,        32'h00000001);
      chk("f5_crc_ok", 32'(out_crc_ok), 32'd1);
      release_out("f5");

      // 6: reset mid-frame
      send(8'hA5);
      send(8'h11);
      rst_n = 1'b0;
      #1;
      chk("mr_in_ready",   32'(in_ready),   32'd1);
      chk("mr_out_valid",  32'(out_valid),  32'd0);
      chk("mr_out_data",   out_data,        32'h0);
      chk("mr_out_crc_ok", 32'(out_crc_ok), 32'd0);
      chk("mr_frame_err",  32'(frame_err),  32'd0);
      chk("mr_err_count",  32'(err_count),  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(32'hDEADBEEF, crc_dbef);
      $display("frame 6: data=%h crc_ok=%b valid=%b", out_data, out_crc_ok, out_valid);
      chk("f6_valid",     32'(out_valid),  32'd1);
      chk("f6_data",      out_data,        32'hDEADBEEF);
      chk("f6_crc_ok",    32'(out_crc_ok), 32'd1);
      chk("f6_err_count", 32'(err_count),  32'd0);
      release_out("f6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
